// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants plus the colour, config and pipeline-flag types used by
// the VGA display path.
package vga_timing_pkg;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    localparam int unsigned DefHTotal      = DefHActive + DefHFp + DefHSync + DefHBp;
    localparam int unsigned DefVTotal      = DefVActive + DefVFp + DefVSync + DefVBp;
    localparam int unsigned DefHSyncStart  = DefHActive + DefHFp;
    localparam int unsigned DefHSyncEnd    = DefHSyncStart + DefHSync;
    localparam int unsigned DefVSyncStart  = DefVActive + DefVFp;
    localparam int unsigned DefVSyncEnd    = DefVSyncStart + DefVSync;

    typedef logic [11:0] rgb444_t;
    localparam rgb444_t BLACK = 12'h000;

    typedef struct packed {
        logic [8:0] width;
        logic [8:0] height;
        logic [9:0] x_off;
        logic [9:0] y_off;
        rgb444_t    border;
    } disp_cfg_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic in_win;
        logic en;
        logic fs;
    } pix_flags_t;

    // off <= pos < off + len, evaluated 11 bits wide so the end never wraps.
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] off,
                                     input logic [8:0] len);
        logic [10:0] stop;
        stop = {1'b0, off} + {2'b00, len};
        return ({1'b0, pos} >= {1'b0, off}) && ({1'b0, pos} < stop);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v raster counters with active-area flag, raw (active-high) sync pulses and
// frame/line boundary strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       active_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       origin_o,
    output logic       line_end_o,
    output logic       frame_end_o
);

    localparam logic [9:0] HLast   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VLast   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HAct    = 10'(H_ACTIVE);
    localparam logic [9:0] VAct    = 10'(V_ACTIVE);
    localparam logic [9:0] HSyncS  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncE  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VSyncS  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncE  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HLast) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign active_o    = (h_cnt_q < HAct) && (v_cnt_q < VAct);
    assign hsync_o     = (h_cnt_q >= HSyncS) && (h_cnt_q < HSyncE);
    assign vsync_o     = (v_cnt_q >= VSyncS) && (v_cnt_q < VSyncE);
    assign origin_o    = (h_cnt_q == '0) && (v_cnt_q == '0);
    assign line_end_o  = (h_cnt_q == HLast);
    assign frame_end_o = (h_cnt_q == HLast) && (v_cnt_q == VLast);

endmodule

// File: rtl/vga_display_ctrl.sv
// Reads the captured frame from BRAM and places it as a window on a VGA raster, filling the
// rest of the active area with a border colour.
module vga_display_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        display_en,
    input  logic [8:0]  axil_cap_width,
    input  logic [8:0]  axil_cap_height,
    input  logic [9:0]  axil_disp_x_off,
    input  logic [9:0]  axil_disp_y_off,
    input  logic [11:0] axil_border_color,
    output logic [16:0] vga_bram_raddr,
    output logic        vga_bram_ren,
    input  logic [11:0] vga_bram_rdata,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_frame_start
);

    localparam int unsigned Depth = RD_LAT + 1;

    logic [9:0] h_cnt, v_cnt;
    logic       active, hsync_raw, vsync_raw, origin, line_end, frame_end;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i       (vga_clk),
        .rst_ni      (sys_rst_n),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .active_o    (active),
        .hsync_o     (hsync_raw),
        .vsync_o     (vsync_raw),
        .origin_o    (origin),
        .line_end_o  (line_end),
        .frame_end_o (frame_end)
    );

    disp_cfg_t  cfg_in, cfg_q, cfg;
    logic       x_hit, y_hit, in_win;
    logic [9:0] col;
    logic [16:0] addr, row_base_q, row_base_d;
    logic [16:0] raddr_q;
    logic        ren_q;
    pix_flags_t  flags_d, pin;
    pix_flags_t  pipe_q [Depth];
    rgb444_t     rgb;

    assign cfg_in = '{width:  axil_cap_width,
                      height: axil_cap_height,
                      x_off:  axil_disp_x_off,
                      y_off:  axil_disp_y_off,
                      border: axil_border_color};

    // The origin pixel already belongs to the new frame, so it sees the incoming config.
    assign cfg = origin ? cfg_in : cfg_q;

    assign x_hit  = in_span(h_cnt, cfg.x_off, cfg.width);
    assign y_hit  = in_span(v_cnt, cfg.y_off, cfg.height);
    assign in_win = active && x_hit && y_hit;
    assign col    = h_cnt - cfg.x_off;
    assign addr   = row_base_q + {7'b0, col};

    // Row base steps on every window line, clipped or not, keeping the address multiplier-free.
    always_comb begin
        row_base_d = row_base_q;
        if (frame_end) begin
            row_base_d = '0;
        end else if (line_end && y_hit) begin
            row_base_d = row_base_q + {8'b0, cfg.width};
        end
    end

    always_comb begin
        flags_d        = '0;
        flags_d.hsync  = hsync_raw;
        flags_d.vsync  = vsync_raw;
        flags_d.active = active;
        flags_d.in_win = in_win;
        flags_d.en     = display_en;
        flags_d.fs     = origin;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cfg_q      <= '0;
            row_base_q <= '0;
            raddr_q    <= '0;
            ren_q      <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) pipe_q[i] <= '0;
        end else begin
            if (origin) cfg_q <= cfg_in;
            row_base_q <= row_base_d;
            ren_q      <= in_win;
            if (in_win) raddr_q <= addr;
            pipe_q[0] <= flags_d;
            for (int unsigned i = 1; i < Depth; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign pin = pipe_q[Depth-1];

    always_comb begin
        rgb = cfg_q.border;
        if (!pin.active || !pin.en) begin
            rgb = BLACK;
        end else if (pin.in_win) begin
            rgb = vga_bram_rdata;
        end
    end

    assign vga_bram_raddr  = raddr_q;
    assign vga_bram_ren    = ren_q;
    assign vga_hsync       = pin.hsync ? SYNC_POL : ~SYNC_POL;
    assign vga_vsync       = pin.vsync ? SYNC_POL : ~SYNC_POL;
    assign vga_r           = rgb[11:8];
    assign vga_g           = rgb[7:4];
    assign vga_b           = rgb[3:0];
    assign vga_frame_start = pin.fs;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench: a reduced 64x48 raster (RD_LAT=2) plus a default 640x480 instance (RD_LAT=1).
module tb_vga_display_ctrl;

    localparam int HT = 80;
    localparam int FRAME = 4400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en;
    logic [8:0]  w, h, w2, h2;
    logic [9:0]  xo, yo, xo2, yo2;
    logic [11:0] border;

    logic [16:0] raddr1, raddr2;
    logic        ren1, ren2, hs1, hs2, vs1, vs2, fs1, fs2;
    logic [3:0]  r1, g1, b1, r2, g2, b2;
    logic [11:0] rgb1, rgb2;
    logic [11:0] m1_s1, m1_s2, m2_s1;

    assign rgb1 = {r1, g1, b1};
    assign rgb2 = {r2, g2, b2};

    vga_display_ctrl #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b0), .RD_LAT (2)
    ) dut (
        .vga_clk (clk), .sys_rst_n (rst_n), .display_en (en),
        .axil_cap_width (w), .axil_cap_height (h),
        .axil_disp_x_off (xo), .axil_disp_y_off (yo), .axil_border_color (border),
        .vga_bram_raddr (raddr1), .vga_bram_ren (ren1), .vga_bram_rdata (m1_s2),
        .vga_hsync (hs1), .vga_vsync (vs1),
        .vga_r (r1), .vga_g (g1), .vga_b (b1), .vga_frame_start (fs1)
    );

    vga_display_ctrl #(
        .RD_LAT (1)
    ) dut2 (
        .vga_clk (clk), .sys_rst_n (rst_n), .display_en (en),
        .axil_cap_width (w2), .axil_cap_height (h2),
        .axil_disp_x_off (xo2), .axil_disp_y_off (yo2), .axil_border_color (border),
        .vga_bram_raddr (raddr2), .vga_bram_ren (ren2), .vga_bram_rdata (m2_s1),
        .vga_hsync (hs2), .vga_vsync (vs2),
        .vga_r (r2), .vga_g (g2), .vga_b (b2), .vga_frame_start (fs2)
    );

    // BRAM models return addr[11:0] with the configured read latency.
    int          ren_cnt = 0;
    logic [16:0] last_addr = '0;
    always @(posedge clk) begin
        if (ren1) begin
            ren_cnt   <= ren_cnt + 1;
            last_addr <= raddr1;
            m1_s1     <= raddr1[11:0];
        end
        m1_s2 <= m1_s1;
        if (ren2) m2_s1 <= raddr2[11:0];
    end

    int total = 0;
    int bad   = 0;
    int pos   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic goto(input int x, input int y);
        int target;
        target = y * HT + x;
        while (pos < target) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
        goto(x, y);
        check(tag, {20'b0, rgb1}, {20'b0, exp});
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs1 && n < 2 * FRAME + 10);
        check("fs_seen", {31'b0, fs1}, 32'd1);
        pos = 0;
    endtask

    int n, base, t_fs1, t_fs2, t_hs1, t_hs2;
    logic [11:0] d2 [6];

    initial begin
        rst_n = 1'b0; en = 1'b1; border = 12'hF00;
        w = '0; h = '0; xo = '0; yo = '0;
        w2 = 9'd4; h2 = 9'd1; xo2 = '0; yo2 = '0;
        t_fs1 = 0; t_fs2 = 0; t_hs1 = 0; t_hs2 = 0;
        repeat (3) @(negedge clk);
        check("rst_hsync", {31'b0, hs1}, 32'd1);
        check("rst_vsync", {31'b0, vs1}, 32'd1);
        check("rst_rgb", {20'b0, rgb1}, 32'd0);
        check("rst_ren", {31'b0, ren1}, 32'd0);
        check("rst_raddr", {15'b0, raddr1}, 32'd0);
        check("rst_fs", {31'b0, fs1}, 32'd0);
        check("rst_hsync2", {31'b0, hs2}, 32'd1);

        // Release: first-frame timing on both instances.
        rst_n = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (fs1 && t_fs1 == 0) t_fs1 = k;
            if (fs2 && t_fs2 == 0) t_fs2 = k;
            if (!hs1 && t_hs1 == 0) t_hs1 = k;
            if (!hs2 && t_hs2 == 0) t_hs2 = k;
            case (k)
                2:   d2[0] = rgb2;
                3:   d2[1] = rgb2;
                5:   d2[2] = rgb2;
                6:   d2[3] = rgb2;
                641: d2[4] = rgb2;
                642: d2[5] = rgb2;
                default: ;
            endcase
        end
        check("fs1_lat", t_fs1, 32'd3);
        check("fs2_lat", t_fs2, 32'd2);
        check("hs1_first_fall", t_hs1, 32'd71);
        check("hs2_first_fall", t_hs2, 32'd658);
        check("d2_px0", {20'b0, d2[0]}, 32'h000);
        check("d2_px1", {20'b0, d2[1]}, 32'h001);
        check("d2_px3", {20'b0, d2[2]}, 32'h003);
        check("d2_px4_border", {20'b0, d2[3]}, 32'hF00);
        check("d2_px639", {20'b0, d2[4]}, 32'hF00);
        check("d2_px640_blank", {20'b0, d2[5]}, 32'h000);
        pos = 1000 - t_fs1;

        // No window: border everywhere, sync edges, no reads.
        base = pos;
        wait_fs(n);
        check("period1", base + n, FRAME);
        base = ren_cnt;
        pix("t1_00", 0, 0, 12'hF00);
        pix("t1_63_0", 63, 0, 12'hF00);
        pix("t1_64_blank", 64, 0, 12'h000);
        goto(67, 0); check("t1_hs67", {31'b0, hs1}, 32'd1);
        goto(68, 0); check("t1_hs68", {31'b0, hs1}, 32'd0);
        goto(75, 0); check("t1_hs75", {31'b0, hs1}, 32'd0);
        goto(76, 0); check("t1_hs76", {31'b0, hs1}, 32'd1);
        pix("t1_63_47", 63, 47, 12'hF00);
        goto(0, 49); check("t1_vs49", {31'b0, vs1}, 32'd1);
        goto(0, 50); check("t1_vs50", {31'b0, vs1}, 32'd0);
        goto(79, 51); check("t1_vs51", {31'b0, vs1}, 32'd0);
        goto(0, 52); check("t1_vs52", {31'b0, vs1}, 32'd1);
        check("t1_no_ren", ren_cnt - base, 32'd0);
        w = 9'd32; h = 9'd24; xo = 10'd16; yo = 10'd12;

        // Window at offset.
        base = pos;
        wait_fs(n);
        check("period2", base + n, FRAME);
        base = ren_cnt;
        pix("t2_15_12_border", 15, 12, 12'hF00);
        pix("t2_16_12", 16, 12, 12'h000);
        pix("t2_17_12", 17, 12, 12'h001);
        pix("t2_47_12", 47, 12, 12'h01F);
        pix("t2_48_12_border", 48, 12, 12'hF00);
        pix("t2_16_13", 16, 13, 12'h020);
        pix("t2_16_35", 16, 35, 12'h2E0);
        pix("t2_16_36_border", 16, 36, 12'hF00);
        goto(0, 40);
        check("t2_ren_count", ren_cnt - base, 32'd768);
        check("t2_last_addr", {15'b0, last_addr}, 32'd767);
        w = 9'd20; h = 9'd4; xo = 10'd50; yo = 10'd2;

        // Horizontal clipping.
        wait_fs(n);
        pix("t3_49_2_border", 49, 2, 12'hF00);
        pix("t3_50_2", 50, 2, 12'h000);
        pix("t3_63_2", 63, 2, 12'h00D);
        pix("t3_64_2_blank", 64, 2, 12'h000);
        pix("t3_50_3", 50, 3, 12'h014);
        pix("t3_63_3", 63, 3, 12'h021);
        pix("t3_50_5", 50, 5, 12'h03C);
        pix("t3_50_6_border", 50, 6, 12'hF00);
        goto(0, 40);
        w = 9'd8; h = 9'd4; xo = 10'd20; yo = 10'd30;

        // Mid-frame config write only affects the next frame.
        wait_fs(n);
        goto(0, 20);
        xo = 10'd0;
        pix("t4_cur_0_30", 0, 30, 12'hF00);
        pix("t4_cur_20_30", 20, 30, 12'h000);
        pix("t4_cur_27_31", 27, 31, 12'h00F);
        pix("t4_cur_28_30", 28, 31, 12'hF00);
        wait_fs(n);
        pix("t4_nxt_0_30", 0, 30, 12'h000);
        pix("t4_nxt_7_30", 7, 30, 12'h007);
        pix("t4_nxt_8_30", 8, 30, 12'hF00);
        pix("t4_nxt_20_30", 20, 30, 12'hF00);
        goto(0, 40);
        en = 1'b0;

        // Display disabled, then asynchronous reset mid-frame.
        wait_fs(n);
        pix("t5_off_0_0", 0, 0, 12'h000);
        goto(67, 5); check("t5_hs67", {31'b0, hs1}, 32'd1);
        goto(68, 5); check("t5_hs68", {31'b0, hs1}, 32'd0);
        pix("t5_off_0_30", 0, 30, 12'h000);
        pix("t5_off_10_10", 10, 10, 12'h000);
        goto(40, 30);
        en = 1'b1;
        pix("t5_on_4_31", 4, 31, 12'h00C);
        check("t5_ren", {31'b0, ren1}, 32'd1);
        check("t5_raddr", {15'b0, raddr1}, 32'd14);
        rst_n = 1'b0;
        #1;
        check("t5_rst_rgb", {20'b0, rgb1}, 32'd0);
        check("t5_rst_ren", {31'b0, ren1}, 32'd0);
        check("t5_rst_raddr", {15'b0, raddr1}, 32'd0);
        check("t5_rst_vsync", {31'b0, vs1}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); check("t5_fs_c1", {31'b0, fs1}, 32'd0);
        @(negedge clk); check("t5_fs_c2", {31'b0, fs1}, 32'd0);
        @(negedge clk); check("t5_fs_c3", {31'b0, fs1}, 32'd1);
        pos = 0;
        pix("t5_re_1_0", 1, 0, 12'hF00);
        goto(68, 0); check("t5_re_hs68", {31'b0, hs1}, 32'd0);
        pix("t5_re_3_30", 3, 30, 12'h003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
